// File: rtl/aes_host_pkg.sv
// Shared state type and chip widths for the AES host driver.
// Width values mirror the chip_defines.v macros of chip_top.
package aes_host_pkg;

   localparam int SEED_KEY_WIDTH   = 128;
   localparam int BLOCK_DATA_WIDTH = 128;
   localparam int SBOX_ROWS        = 16;
   localparam int SBOX_COLS        = 16;
   localparam int SBOX_FLAT_WIDTH  = SBOX_ROWS * SBOX_COLS * 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LD_SBOX,
      ST_LD_KEY,
      ST_STREAM
   } host_state_e;

endpackage

// File: rtl/aes_host_fifo.sv
// Small synchronous FIFO with occupancy count, used for the plaintext and result queues.
// Pushes while full and pops while empty are ignored.
module aes_host_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/aes_host_driver.sv
// Host-side master for the AES chip: loads S-box and key, streams plaintext under
// data_accept and result-FIFO credit, and queues every returned block for the host.
module aes_host_driver
   import aes_host_pkg::*;
#(
   parameter int KEY_W     = SEED_KEY_WIDTH,
   parameter int BLK_W     = BLOCK_DATA_WIDTH,
   parameter int SBOX_W    = SBOX_FLAT_WIDTH,
   parameter int IN_DEPTH  = 4,
   parameter int RES_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic              cfg_sbox_load,
   input  logic [KEY_W-1:0]  cfg_key,
   input  logic [SBOX_W-1:0] cfg_sbox,
   input  logic [BLK_W-1:0]  h_data,
   input  logic              h_vld,
   output logic              h_rdy,
   output logic [BLK_W-1:0]  r_data,
   output logic              r_vld,
   input  logic              r_rdy,
   output logic              busy,
   output logic              ovf_err,
   output logic [KEY_W-1:0]  key_in,
   output logic              key_in_vld,
   output logic [BLK_W-1:0]  data_in,
   output logic              data_in_vld,
   output logic [SBOX_W-1:0] sbox_in,
   output logic              sbox_in_vld,
   input  logic              data_accept,
   input  logic [BLK_W-1:0]  data_out,
   input  logic              data_out_vld
);

   localparam int CW = $clog2(RES_DEPTH) + 1;

   host_state_e       state_q, state_d;
   logic [KEY_W-1:0]  key_lat_q, key_lat_d;
   logic [SBOX_W-1:0] sbox_lat_q, sbox_lat_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic              ovf_q, ovf_d;
   logic [KEY_W-1:0]  key_in_q, key_in_d;
   logic              key_in_vld_q, key_in_vld_d;
   logic [BLK_W-1:0]  data_in_q, data_in_d;
   logic              data_in_vld_q, data_in_vld_d;
   logic [SBOX_W-1:0] sbox_in_q, sbox_in_d;
   logic              sbox_in_vld_q, sbox_in_vld_d;

   logic                        in_full, in_empty, in_push;
   logic [$clog2(IN_DEPTH):0]   in_level_unused;
   logic [BLK_W-1:0]            in_head;
   logic                        res_full, res_empty;
   logic [CW-1:0]               res_count;
   logic [CW-1:0]               credit;
   logic                        cfg_take, issue;

   assign h_rdy   = reset && !in_full;
   assign in_push = h_vld && h_rdy;
   assign r_vld   = !res_empty;
   // Credit reserves a result slot for every block still inside the core.
   assign credit  = CW'(RES_DEPTH) - res_count - inflight_q;

   aes_host_fifo #(.WIDTH(BLK_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (in_push),
      .push_data (h_data),
      .pop       (issue),
      .pop_data  (in_head),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_level_unused)
   );

   aes_host_fifo #(.WIDTH(BLK_W), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (data_out_vld),
      .push_data (data_out),
      .pop       (r_rdy),
      .pop_data  (r_data),
      .full      (res_full),
      .empty     (res_empty),
      .count     (res_count)
   );

   always_comb begin
      state_d       = state_q;
      key_lat_d     = key_lat_q;
      sbox_lat_d    = sbox_lat_q;
      inflight_d    = inflight_q;
      ovf_d         = ovf_q | (data_out_vld & res_full);
      key_in_d      = key_in_q;
      key_in_vld_d  = 1'b0;
      sbox_in_d     = sbox_in_q;
      sbox_in_vld_d = 1'b0;
      data_in_d     = data_in_q;
      data_in_vld_d = 1'b0;
      cfg_take      = 1'b0;
      issue         = 1'b0;
      case (state_q)
         ST_IDLE: cfg_take = cfg_start;
         ST_LD_SBOX: begin
            sbox_in_d     = sbox_lat_q;
            sbox_in_vld_d = 1'b1;
            state_d       = ST_LD_KEY;
         end
         ST_LD_KEY: begin
            key_in_d     = key_lat_q;
            key_in_vld_d = 1'b1;
            state_d      = ST_STREAM;
         end
         ST_STREAM: begin
            // Reconfiguration only once the core is drained; it wins over an issue.
            cfg_take = cfg_start && (inflight_q == '0);
            issue    = !cfg_take && !in_empty && data_accept && (credit != '0);
         end
         default: state_d = ST_IDLE;
      endcase
      if (cfg_take) begin
         key_lat_d  = cfg_key;
         sbox_lat_d = cfg_sbox;
         state_d    = cfg_sbox_load ? ST_LD_SBOX : ST_LD_KEY;
      end
      if (issue) begin
         data_in_d     = in_head;
         data_in_vld_d = 1'b1;
      end
      case ({issue, data_out_vld})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         key_lat_q     <= '0;
         sbox_lat_q    <= '0;
         inflight_q    <= '0;
         ovf_q         <= 1'b0;
         key_in_q      <= '0;
         key_in_vld_q  <= 1'b0;
         sbox_in_q     <= '0;
         sbox_in_vld_q <= 1'b0;
         data_in_q     <= '0;
         data_in_vld_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_lat_q     <= key_lat_d;
         sbox_lat_q    <= sbox_lat_d;
         inflight_q    <= inflight_d;
         ovf_q         <= ovf_d;
         key_in_q      <= key_in_d;
         key_in_vld_q  <= key_in_vld_d;
         sbox_in_q     <= sbox_in_d;
         sbox_in_vld_q <= sbox_in_vld_d;
         data_in_q     <= data_in_d;
         data_in_vld_q <= data_in_vld_d;
      end
   end

   assign busy        = !((state_q == ST_IDLE) || ((state_q == ST_STREAM) && (inflight_q == '0)));
   assign ovf_err     = ovf_q;
   assign key_in      = key_in_q;
   assign key_in_vld  = key_in_vld_q;
   assign sbox_in     = sbox_in_q;
   assign sbox_in_vld = sbox_in_vld_q;
   assign data_in     = data_in_q;
   assign data_in_vld = data_in_vld_q;

endmodule

// File: tb/tb_aes_host_driver.sv
// Self-checking bench for aes_host_driver: behavioural core model, in-order
// result scoreboard, table-driven config/stream vectors and directed corner cases.
module tb_aes_host_driver;

   localparam int KEY_W     = 128;
   localparam int BLK_W     = 128;
   localparam int SBOX_W    = 2048;
   localparam int IN_DEPTH  = 4;
   localparam int RES_DEPTH = 4;
   localparam int CORE_LAT  = 3;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] FIPS_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] FIPS_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
   localparam logic [127:0] MASK     = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
   localparam logic [127:0] K2       = 128'hdeadbeef_01234567_89abcdef_feedf00d;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_start = 1'b0;
   logic              cfg_sbox_load = 1'b0;
   logic [KEY_W-1:0]  cfg_key = '0;
   logic [SBOX_W-1:0] cfg_sbox = '0;
   logic [BLK_W-1:0]  h_data = '0;
   logic              h_vld = 1'b0;
   logic              h_rdy;
   logic [BLK_W-1:0]  r_data;
   logic              r_vld;
   logic              r_rdy = 1'b0;
   logic              busy, ovf_err;
   logic [KEY_W-1:0]  key_in;
   logic              key_in_vld;
   logic [BLK_W-1:0]  data_in;
   logic              data_in_vld;
   logic [SBOX_W-1:0] sbox_in;
   logic              sbox_in_vld;
   logic              data_accept = 1'b1;
   logic [BLK_W-1:0]  data_out = '0;
   logic              data_out_vld = 1'b0;
   logic              core_hold = 1'b0;

   typedef struct {
      logic [127:0] data;
      int           due;
   } core_item_t;

   typedef struct {
      logic         sbox_load;
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] exp_ct;
      int           key_cyc;
   } vec_t;

   core_item_t   core_q[$];
   core_item_t   item;
   logic [127:0] pt_q[$];
   logic [127:0] exp_q[$];
   vec_t         vecs[4];
   logic [SBOX_W-1:0] sbox_v;
   int n_tests = 0;
   int n_fail  = 0;
   int n_issue = 0;
   int cyc     = 0;

   aes_host_driver #(
      .KEY_W(KEY_W), .BLK_W(BLK_W), .SBOX_W(SBOX_W),
      .IN_DEPTH(IN_DEPTH), .RES_DEPTH(RES_DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_start(cfg_start), .cfg_sbox_load(cfg_sbox_load),
      .cfg_key(cfg_key), .cfg_sbox(cfg_sbox),
      .h_data(h_data), .h_vld(h_vld), .h_rdy(h_rdy),
      .r_data(r_data), .r_vld(r_vld), .r_rdy(r_rdy),
      .busy(busy), .ovf_err(ovf_err),
      .key_in(key_in), .key_in_vld(key_in_vld),
      .data_in(data_in), .data_in_vld(data_in_vld),
      .sbox_in(sbox_in), .sbox_in_vld(sbox_in_vld),
      .data_accept(data_accept), .data_out(data_out), .data_out_vld(data_out_vld)
   );

   always #5 clock = ~clock;

   // Stand-in for the AES core: FIPS-197 vector is exact, anything else gets a fixed scramble.
   function automatic logic [127:0] core_fn(input logic [127:0] pt);
      if (pt == FIPS_PT) return FIPS_CT;
      return {pt[63:0], pt[127:64]} ^ MASK;
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic host_push(input logic [127:0] d);
      int t = 0;
      h_data = d;
      h_vld  = 1'b1;
      while (!h_rdy && t < 200) begin
         tick();
         t++;
      end
      if (!h_rdy) report_fail("h_rdy wait", "h_rdy stayed 0 for 200 cycles, required 1");
      tick();
      h_vld = 1'b0;
   endtask

   task automatic wait_rvld(input string name);
      int t = 0;
      while (!r_vld && t < 100) begin
         tick();
         t++;
      end
      if (!r_vld) report_fail(name, "r_vld stayed 0 for 100 cycles, required 1");
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || r_vld || busy) && t < 400) begin
         tick();
         t++;
      end
      check_output(name, 128'(exp_q.size()), 128'd0);
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         h_vld       = ($urandom_range(0, 3) != 0);
         h_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
         r_rdy       = ($urandom_range(0, 2) != 0);
         data_accept = ($urandom_range(0, 3) != 0);
         core_hold   = ($urandom_range(0, 4) == 0);
         tick();
      end
      h_vld       = 1'b0;
      r_rdy       = 1'b1;
      data_accept = 1'b1;
      core_hold   = 1'b0;
   endtask

   // Core model: returns each accepted block CORE_LAT cycles later, one per cycle, in order.
   always @(posedge clock) begin
      #1;
      cyc = cyc + 1;
      data_out_vld = 1'b0;
      if (!reset) begin
         core_q.delete();
      end else if (!core_hold && core_q.size() > 0 && core_q[0].due <= cyc) begin
         data_out     = core_fn(core_q[0].data);
         data_out_vld = 1'b1;
         void'(core_q.pop_front());
      end
   end

   // Scoreboard: plaintext issue order and result order follow host push order.
   always @(negedge clock) begin
      if (!reset) begin
         pt_q.delete();
         exp_q.delete();
         core_q.delete();
      end else begin
         if (h_vld && h_rdy) begin
            pt_q.push_back(h_data);
            exp_q.push_back(core_fn(h_data));
         end
         if (data_in_vld) begin
            n_issue++;
            if (pt_q.size() == 0) report_fail("issue order", "data_in_vld with no pending plaintext");
            else check_output("issue order", data_in, pt_q.pop_front());
            item.data = data_in;
            item.due  = cyc + CORE_LAT;
            core_q.push_back(item);
         end
         if (r_vld && r_rdy) begin
            if (exp_q.size() == 0) report_fail("result order", "r_vld with no expected result");
            else check_output("result order", r_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base, key_at, sbox_seen, seen;

      reset     = 1'b0;
      cfg_start = 1'b1;
      repeat (3) tick();
      check_output("reset key_in_vld", key_in_vld, 0);
      check_output("reset sbox_in_vld", sbox_in_vld, 0);
      check_output("reset data_in_vld", data_in_vld, 0);
      check_output("reset key_in", key_in, 0);
      check_output("reset data_in", data_in, 0);
      check_output("reset sbox_in zero", 128'(sbox_in == '0), 1);
      check_output("reset r_vld", r_vld, 0);
      check_output("reset busy", busy, 0);
      check_output("reset h_rdy", h_rdy, 0);
      check_output("reset ovf_err", ovf_err, 0);
      reset     = 1'b1;
      cfg_start = 1'b0;
      tick();
      check_output("post-reset h_rdy", h_rdy, 1);
      check_output("post-reset busy", busy, 0);

      vecs[0] = '{1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 2};
      vecs[1] = '{1'b0, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                  128'h00112233_44556677_8899aabb_ccddeeff,
                  core_fn(128'h00112233_44556677_8899aabb_ccddeeff), 1};
      vecs[2] = '{1'b1, {128{1'b1}}, 128'h01234567_89abcdef_fedcba98_76543210,
                  core_fn(128'h01234567_89abcdef_fedcba98_76543210), 2};
      vecs[3] = '{1'b0, 128'h0, 128'h0, core_fn(128'h0), 1};

      r_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < SBOX_W / 32; j++) sbox_v[j*32 +: 32] = $urandom();
         cfg_sbox_load = vecs[i].sbox_load;
         cfg_key       = vecs[i].key;
         cfg_sbox      = sbox_v;
         cfg_start     = 1'b1;
         tick();
         cfg_start = 1'b0;
         cfg_key   = ~vecs[i].key;
         cfg_sbox  = ~sbox_v;
         sbox_seen = 0;
         key_at    = 0;
         for (int k = 1; k <= 3; k++) begin
            tick();
            if (sbox_in_vld) begin
               sbox_seen++;
               check_output("sbox_in value", 128'(sbox_in == sbox_v), 1);
            end
            if (key_in_vld) begin
               key_at = k;
               check_output("key_in value", key_in, vecs[i].key);
            end
         end
         check_output("sbox_in_vld pulses", 128'(sbox_seen), 128'(vecs[i].sbox_load));
         check_output("key_in_vld cycle", 128'(key_at), 128'(vecs[i].key_cyc));
         host_push(vecs[i].pt);
         wait_rvld("stream r_vld");
         check_output("stream r_data", r_data, vecs[i].exp_ct);
         r_rdy = 1'b1;
         tick();
         r_rdy = 1'b0;
         check_output("stream r_vld cleared", r_vld, 0);
         check_output("stream busy idle", busy, 0);
      end

      // Credit stall: four result slots, six blocks.
      base = n_issue;
      for (int i = 0; i < 6; i++) host_push({$urandom(), $urandom(), $urandom(), 32'(i)});
      repeat (20) tick();
      check_output("credit stall issues", 128'(n_issue - base), 4);
      check_output("credit stall ovf_err", ovf_err, 0);
      check_output("credit stall r_vld", r_vld, 1);
      r_rdy = 1'b1;
      wait_drain("credit release drain");
      check_output("credit release issues", 128'(n_issue - base), 6);
      check_output("credit release ovf_err", ovf_err, 0);

      // Accept stall with full input FIFO.
      data_accept = 1'b0;
      for (int i = 0; i < IN_DEPTH; i++) host_push({$urandom(), $urandom(), $urandom(), $urandom()});
      base = n_issue;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         check_output("accept stall h_rdy", h_rdy, 0);
         tick();
         if (data_in_vld) seen++;
      end
      check_output("accept stall data_in_vld", 128'(seen), 0);
      data_accept = 1'b1;
      tick();
      check_output("accept resume data_in_vld", data_in_vld, 1);
      wait_drain("accept resume drain");
      check_output("accept resume issues", 128'(n_issue - base), IN_DEPTH);

      // Reconfiguration guard with one block in flight.
      core_hold = 1'b1;
      host_push(128'hcafef00d_00000000_11111111_22222222);
      seen = 0;
      while (!data_in_vld && seen < 50) begin
         tick();
         seen++;
      end
      if (!data_in_vld) report_fail("guard issue", "data_in_vld never rose within 50 cycles");
      cfg_sbox_load = 1'b0;
      cfg_key       = K2;
      cfg_start     = 1'b1;
      tick();
      cfg_start = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (key_in_vld || sbox_in_vld) seen++;
      end
      check_output("guard ignored cfg_start", 128'(seen), 0);
      check_output("guard busy", busy, 1);
      core_hold = 1'b0;
      wait_drain("guard drain");
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      tick();
      check_output("guard honoured key_in_vld", key_in_vld, 1);
      check_output("guard honoured key_in", key_in, K2);
      check_output("guard ovf_err", ovf_err, 0);
      tick();

      // Reset with plaintext queued drops it.
      data_accept = 1'b0;
      host_push(128'h1);
      host_push(128'h2);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check_output("midreset r_vld", r_vld, 0);
      check_output("midreset busy", busy, 0);
      check_output("midreset h_rdy", h_rdy, 1);
      data_accept   = 1'b1;
      cfg_sbox_load = 1'b0;
      cfg_start     = 1'b1;
      tick();
      cfg_start = 1'b0;
      base = n_issue;
      repeat (6) tick();
      check_output("midreset no stale issue", 128'(n_issue - base), 0);

      // Randomised traffic against the scoreboard.
      apply_stimulus(400);
      wait_drain("random drain");
      check_output("random pending plaintext", 128'(pt_q.size()), 0);
      check_output("random ovf_err", ovf_err, 0);
      check_output("random busy idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_host_driver.md
# aes_host_driver

Host-side master for the AES-128 chip top. It loads the S-box table and the seed key into the core, then streams plaintext blocks from a host FIFO into the core's data port under `data_accept` flow control. It captures every `data_out` result into a credit-protected result FIFO for the host to drain. It sits between the host or bus logic and `chip_top`, driving every chip input and consuming every chip output.

## Interface
Parameters:
- `KEY_W`, `SEED_KEY_WIDTH` (128): seed key width.
- `BLK_W`, `BLOCK_DATA_WIDTH` (128): data block width.
- `SBOX_W`, `sbox_w*sbox_h*8` (2048): flattened S-box width.
- `IN_DEPTH`, 4: plaintext FIFO depth, power of two, ≥2.
- `RES_DEPTH`, 4: result FIFO depth, power of two, ≥2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse that begins a (re)configuration.
- `cfg_sbox_load`  in  1  sampled with `cfg_start`; 1 = load S-box before key.
- `cfg_key`  in  KEY_W  key, sampled with `cfg_start`.
- `cfg_sbox`  in  SBOX_W  S-box, sampled with `cfg_start`.
- `h_data` / `h_vld` / `h_rdy`  in/in/out  BLK_W/1/1  plaintext stream (valid/ready).
- `r_data` / `r_vld` / `r_rdy`  out/out/in  BLK_W/1/1  result stream (valid/ready).
- `busy`  out  1  high in any state other than IDLE or STREAM-with-nothing-in-flight.
- `ovf_err`  out  1  sticky; a `data_out_vld` arrived while the result FIFO was full.
- `key_in`, `key_in_vld`, `data_in`, `data_in_vld`, `sbox_in`, `sbox_in_vld`  out  per chip  chip inputs, all registered.
- `data_accept`, `data_out`, `data_out_vld`  in  per chip  chip outputs.

## Operation
- **Reset values:** all outputs 0, state IDLE, both FIFOs empty, `inflight`=0, `ovf_err`=0. `h_rdy` is 0 in reset and 1 after reset if the input FIFO is not full.
- **States:** IDLE, LD_SBOX, LD_KEY, STREAM.
- **IDLE:** on `cfg_start`, latch `cfg_key` and `cfg_sbox`. Go to LD_SBOX if `cfg_sbox_load`=1, else to LD_KEY.
- **LD_SBOX:** drive `sbox_in`=latched S-box and `sbox_in_vld`=1 for exactly one cycle, then go to LD_KEY.
- **LD_KEY:** drive `key_in`=latched key and `key_in_vld`=1 for exactly one cycle, then go to STREAM.
- **STREAM, issue condition:** a block is issued when the input FIFO is non-empty, `data_accept`=1, and `credit`>0, where `credit` = RES_DEPTH − res_count − inflight.
- **STREAM, on issue:** pop the input FIFO, register `data_in`/`data_in_vld`=1 for one cycle, and increment `inflight`.
- **STREAM, `cfg_start`:** honoured only when `inflight`=0; it re-latches and re-enters LD_SBOX or LD_KEY. Otherwise it is ignored (no queuing). The input FIFO is not flushed by reconfiguration.
- **Result capture (any state):** each `data_out_vld` pushes `data_out` into the result FIFO and decrements `inflight` (saturating at 0). If the result FIFO is full, the word is dropped and `ovf_err` sets.
- **Host plaintext side:** `h_rdy` = input FIFO not full. A push occurs when `h_vld && h_rdy`.
- **Host result side:** a pop occurs when `r_vld && r_rdy`.
- **Simultaneous events:**
  - Push and pop in the same cycle on either FIFO leave the count unchanged.
  - Issue and `data_out_vld` in the same cycle leave `inflight` unchanged.
- **Credit arithmetic:** computed on log2(RES_DEPTH)+1 bits. The credit check guarantees `ovf_err` never sets with a compliant core.
- **Reset mid-operation:** returns to IDLE, drops queued and in-flight data, and clears `ovf_err`.

## Timing
- All chip-side outputs are registered.
- Issue is decided from `data_accept` sampled at edge t; `data_in_vld` is high for t→t+1.
- Back-to-back issues are allowed every cycle while the issue condition holds.
- `cfg_start` at edge t with `cfg_sbox_load`=1:
  - `sbox_in_vld` high for t+1;
  - `key_in_vld` high for t+2;
  - first possible `data_in_vld` at t+3.
- With `cfg_sbox_load`=0, the sequence is one cycle earlier.
- Input FIFO latency: a plaintext word pushed at edge t can be issued at the earliest at edge t+1, so `data_in_vld` is high for t+1→t+2 at the earliest.
- Result FIFO latency: `data_out_vld` at edge t gives `r_vld` from t+1.

## Structure
- Package `aes_host_pkg`:
  - state enum `host_state_e`;
  - width localparams derived from `chip_defines.v` macros.
- Sub-module `aes_host_fifo`:
  - parameters WIDTH and DEPTH;
  - synchronous active-low reset;
  - outputs `full`, `empty`, `count`.
  - Instantiated twice: plaintext and result.
- Top level holds the FSM, the config latches, and the `inflight` counter.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `cfg_start`=1 → all chip inputs 0, `r_vld`=0, `busy`=0.
- **Config sequence:** `cfg_start` with `cfg_sbox_load`=1 and key 0x2b7e1516_28aed2a6_abf71588_09cf4f3c → one `sbox_in_vld` pulse, then one `key_in_vld` pulse carrying that key, in consecutive cycles.
- **Streaming:** push 0x3243f6a8_885a308d_313198a2_e0370734 with core model returning 0x3925841d_02dc09fb_dc118597_196a0b32 → `r_data` equals that ciphertext, `inflight` back to 0.
- **Credit stall:** hold `r_rdy`=0 and push 6 blocks with RES_DEPTH=4 → exactly 4 `data_in_vld` pulses, `ovf_err` stays 0. Then release `r_rdy` → remaining 2 issue in order.
- **Accept stall:** `data_accept`=0 for 10 cycles with input FIFO full → `h_rdy`=0, no `data_in_vld`. Raising `data_accept` → issues resume the next cycle.
- **Reconfiguration guard:** `cfg_start` in STREAM with `inflight`=1 → ignored. The same `cfg_start` after the result returns → `key_in_vld` pulse, and `ovf_err` stays 0.
